// File: rtl/apb_master.sv
// APB3 initiator. It takes one request at a time from a valid/ready request
// port, runs the SETUP/ACCESS phases on the APB bus, and returns read data
// and an error flag on a valid/ready response port. ACCESS can be aborted
// after a programmable number of wait-state cycles.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both high. The initiator holds valid and its payload
// stable until that edge. The request side accepts only in IDLE, and
// req_ready never depends on req_valid.
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_rnw,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] apb_paddr,
    output logic                  apb_psel,
    output logic                  apb_penable,
    output logic                  apb_pwrite,
    output logic [DATA_WIDTH-1:0] apb_pwdata,
    input  logic [DATA_WIDTH-1:0] apb_prdata,
    input  logic                  apb_pready,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // A TIMEOUT of 0 disables the abort entirely. TO_LAST is the counter
    // value seen during the final permitted ACCESS cycle.
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;

    // The request port may only be served from IDLE.
    assign req_ready = (state == IDLE);
    assign state_dbg = state;

    // Transfer sequencer. Every bus and response output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 16'd0;
            apb_paddr   <= '0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_pwdata  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        apb_paddr   <= req_addr;
                        apb_pwrite  <= !req_rnw;
                        apb_pwdata  <= req_wdata;
                        apb_psel    <= 1'b1;
                        apb_penable <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    apb_penable <= 1'b1;
                    wait_cnt    <= 16'd0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // If PREADY arrives in the last allowed cycle, the
                    // transfer completes normally.
                    if (apb_pready) begin
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b0;
                        rsp_rdata   <= apb_pwrite ? '0 : apb_prdata;
                        state       <= RESP;
                    end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end else if (wait_cnt != 16'hffff) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
